fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Consumer end of the branch-decision interface: owns the architectural PC, applies
//  NextPCsrc/target from the branch unit, and sequences instruction fetch.
//  Issues one imem request at a time (valid/ready), captures the response, and presents
//  the instruction to decode/execute with a valid/ready handshake.
//  Sits between instruction memory and the decode/register-read/branch-unit path.
// PARAMETERS
//  XLEN      32        PC / address width
//  RESET_PC  32'h0     PC loaded on reset
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst             in   1     synchronous, active-high reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request this cycle
//  imem_req_addr   out  XLEN  fetch address (= pc)
//  imem_rsp_valid  in   1     response data valid (in order, exactly one per accepted request)
//  imem_rsp_data   in   32    fetched instruction word
//  inst_valid      out  1     instruction available to core
//  inst_ready      in   1     core consumes instruction this cycle
//  inst            out  32    instruction word
//  inst_pc         out  XLEN  PC of inst
//  NextPCsrc       in   1     branch unit decision; sampled only on consume cycle
//  BrTarget        in   XLEN  branch/jump target; sampled only on consume cycle
//  flush           in   1     external redirect (trap/debug), highest priority
//  flush_pc        in   XLEN  redirect address for flush
//  misalign        out  1     sticky: a taken target had [1:0]!=0
//  retired_cnt     out  32    count of consumed instructions, wraps mod 2^32
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): state=FETCH, pc=RESET_PC, imem_req_valid=0 that cycle,
//   inst_valid=0, inst=0, inst_pc=0, misalign=0, retired_cnt=0. rst overrides all inputs.
//  States: FETCH, WAIT, DELIVER, DROP, HALT.
//  FETCH: imem_req_valid=1, imem_req_addr=pc (held stable until accepted);
//   req_valid&req_ready -> WAIT.
//  WAIT: rsp_valid -> latch inst=rsp_data, inst_pc=pc; -> DELIVER. inst_valid rises the
//   cycle after rsp_valid (1-cycle registered latency); rsp_valid in same cycle as accept not allowed.
//  DELIVER: inst_valid=1, inst/inst_pc stable until consumed. inst_valid&inst_ready:
//   retired_cnt+=1; if NextPCsrc: target=BrTarget; if target[1:0]!=0 -> misalign=1, -> HALT
//   else pc=target -> FETCH. If !NextPCsrc: pc=pc+4 (mod 2^XLEN wrap) -> FETCH.
//   Fetch of next PC starts the cycle after consume (FETCH asserts req next cycle).
//  HALT: no requests, inst_valid=0; leaves only via flush or rst.
//  flush (any state, takes priority over consume and rsp): pc=flush_pc, inst_valid=0 next cycle,
//   consume in same cycle is NOT counted; flush_pc[1:0]!=0 -> misalign=1, -> HALT.
//   From WAIT, or from FETCH with req accepted same cycle: -> DROP (request outstanding).
//   Otherwise -> FETCH.
//  DROP: discard next rsp_valid (inst unchanged, not presented), then -> FETCH. Further flush
//   in DROP updates pc only, stays DROP.
//  misalign clears only on rst. At most one outstanding imem request at all times.
// STRUCTURE
//  fetch_pkg: fetch_state_e enum (FETCH,WAIT,DELIVER,DROP,HALT), PC_STEP=4, XLEN default.
//  Single flat module; next-PC mux is inline (no sub-module warranted).
// TESTING
//  1 Reset, ready=1, rsp 1 cycle later, inst_ready=1, NextPCsrc=0 -> addrs 0,4,8; retired_cnt 3.
//  2 At inst_pc=0x10 consume with NextPCsrc=1, BrTarget=0x40 -> next imem_req_addr=0x40.
//  3 NextPCsrc=1, BrTarget=0x42 -> misalign=1, HALT, no further req; flush_pc=0x80 -> fetch 0x80.
//  4 flush(flush_pc=0x100) while WAIT at 0x8 -> rsp for 0x8 dropped, next req 0x100, no inst_valid for 0x8.
//  5 imem_req_ready=0 for 5 cycles, inst_ready=0 for 3 cycles -> addr/inst/inst_pc held stable.
//  6 rst asserted in DELIVER -> next cycle inst_valid=0, pc=RESET_PC, counters 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    WAIT    = 3'd1,
    DELIVER = 3'd2,
    DROP    = 3'd3,
    HALT    = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC: issues one imem fetch at a time, presents the word to the
// core, and applies branch decisions / external redirects on consume or flush.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            NextPCsrc,
  input  logic [XLEN-1:0] BrTarget,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misalign,
  output logic [31:0]     retired_cnt
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            req_fire;
  logic            rsp_pending;

  // Request is gated by rst so nothing leaves the block during the reset cycle.
  assign imem_req_valid = (state == FETCH) && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is still owed to us after this cycle; a flush must then discard it.
  assign rsp_pending = ((state == WAIT) && !imem_rsp_valid) ||
                       ((state == DROP) && !imem_rsp_valid) ||
                       ((state == FETCH) && req_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      misalign    <= 1'b0;
      retired_cnt <= '0;
    end else if (flush) begin
      pc         <= flush_pc;
      inst_valid <= 1'b0;
      if (flush_pc[1:0] != 2'b00) begin
        misalign <= 1'b1;
        state    <= HALT;
      end else if (rsp_pending) begin
        state <= DROP;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: if (req_fire) state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= DELIVER;
          end
        end
        DELIVER: begin
          if (inst_ready) begin
            retired_cnt <= retired_cnt + 32'd1;
            inst_valid  <= 1'b0;
            if (NextPCsrc) begin
              if (BrTarget[1:0] != 2'b00) begin
                misalign <= 1'b1;
                state    <= HALT;
              end else begin
                pc    <= BrTarget;
                state <= FETCH;
              end
            end else begin
              pc    <= pc + XLEN'(PC_STEP);
              state <= FETCH;
            end
          end
        end
        DROP: if (imem_rsp_valid) state <= FETCH;
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
